rst_seq_gen: RTL and testbench

//  Parametrised successor to the game reset generator. Holds the game in reset until the PLL locks,

---
 rtl/rst_seq_gen_pkg.sv | 14 +
 rtl/rst_seq_gen_phase_timer.sv | 35 +++
 rtl/rst_seq_gen.sv | 98 +++++++++
 tb/tb_rst_seq_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the game reset sequencer and anything that decodes its phase output.
package rst_seq_gen_pkg;

  typedef enum logic [1:0] {
    PH_HOLD = 2'd0,
    PH_ARM  = 2'd1,
    PH_RUN  = 2'd2
  } phase_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_gen_phase_timer.sv
// Per-phase cycle timer: counts enabled cycles, flags the terminal cycle and wraps to zero.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = en && (cnt_q == last_val);

  // Clear wins over the wrap, so an abort on the terminal cycle still restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || done) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Game reset sequencer: waits for PLL lock, steps HOLD -> ARM -> RUN, and drops back to HOLD
// on player loss, restart or (optionally) lock loss, recording the loss source and round count.
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int HOLD_CYC    = 33554432,
  parameter int ARM_CYC     = 33554431,
  parameter int LOCK_STRICT = 0,
  parameter int RND_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lock,
  input  logic [NUM_SRC-1:0] loss,
  input  logic               restart,
  output logic               game_rst_n,
  output logic               gmv,
  output logic [1:0]         phase,
  output logic [NUM_SRC-1:0] last_loss,
  output logic [RND_W-1:0]   round_cnt
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYC, ARM_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYC - 1);

  phase_e               state_q, state_d;
  logic [NUM_SRC-1:0]   last_loss_q, last_loss_d;
  logic [RND_W-1:0]     round_cnt_q, round_cnt_d;
  logic                 go_hold;
  logic                 strict_drop;
  logic                 timer_en;
  logic                 timer_done;
  logic [CNT_W-1:0]     timer_last;

  assign timer_en    = lock && (state_q != PH_RUN);
  assign timer_last  = (state_q == PH_ARM) ? ARM_LAST : HOLD_LAST;
  assign strict_drop = (LOCK_STRICT != 0) && !lock && (state_q != PH_HOLD);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (go_hold),
    .en      (timer_en),
    .last_val(timer_last),
    .done    (timer_done)
  );

  // Priority: restart, then loss in RUN, then strict lock drop, then timer expiry.
  always_comb begin
    state_d     = state_q;
    last_loss_d = last_loss_q;
    round_cnt_d = round_cnt_q;
    go_hold     = 1'b0;
    if (restart) begin
      go_hold = 1'b1;
    end else if ((state_q == PH_RUN) && (|loss)) begin
      go_hold     = 1'b1;
      last_loss_d = loss;
      if (!(&round_cnt_q)) begin
        round_cnt_d = round_cnt_q + RND_W'(1);
      end
    end else if (strict_drop) begin
      go_hold = 1'b1;
    end else if (timer_done) begin
      case (state_q)
        PH_HOLD: state_d = PH_ARM;
        PH_ARM:  state_d = PH_RUN;
        default: state_d = PH_HOLD;
      endcase
    end
    if (go_hold) begin
      state_d = PH_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PH_HOLD;
      last_loss_q <= '0;
      round_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_loss_q <= last_loss_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign game_rst_n = (state_q == PH_RUN);
  assign gmv        = (state_q == PH_ARM) || (state_q == PH_RUN);
  assign phase      = state_q;
  assign last_loss  = last_loss_q;
  assign round_cnt  = round_cnt_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: a vector table for the main sequence plus hand-written corner cases.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic [1:0] loss;
  logic       restart;

  logic       grn_lax, gmv_lax, grn_str, gmv_str;
  logic [1:0] ph_lax, last_lax, rnd_lax, ph_str, last_str, rnd_str;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_SRC(2), .HOLD_CYC(4), .ARM_CYC(3), .LOCK_STRICT(0), .RND_W(2)
  ) dut_lax (
    .clk(clk), .rst_n(rst_n), .lock(lock), .loss(loss), .restart(restart),
    .game_rst_n(grn_lax), .gmv(gmv_lax), .phase(ph_lax), .last_loss(last_lax), .round_cnt(rnd_lax)
  );

  rst_seq_gen #(
    .NUM_SRC(2), .HOLD_CYC(4), .ARM_CYC(3), .LOCK_STRICT(1), .RND_W(2)
  ) dut_strict (
    .clk(clk), .rst_n(rst_n), .lock(lock), .loss(loss), .restart(restart),
    .game_rst_n(grn_str), .gmv(gmv_str), .phase(ph_str), .last_loss(last_str), .round_cnt(rnd_str)
  );

  typedef struct {
    logic       rst_n;
    logic       lock;
    logic [1:0] loss;
    logic       restart;
    logic [1:0] ph;
    logic       grn;
    logic       gmv;
    logic [1:0] last;
    logic [1:0] rnd;
  } vec_t;

  vec_t vecs[20];

  // Drive one cycle of inputs and sample 1ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic lk, input logic [1:0] ls, input logic rs);
    rst_n   = r;
    lock    = lk;
    loss    = ls;
    restart = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit strict, input logic [1:0] ph,
                             input logic grn, input logic gm, input logic [1:0] last,
                             input logic [1:0] rnd);
    logic [7:0] act, exp;
    exp = {ph, grn, gm, last, rnd};
    act = strict ? {ph_str, grn_str, gmv_str, last_str, rnd_str}
                 : {ph_lax, grn_lax, gmv_lax, last_lax, rnd_lax};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got phase=%0d grn=%b gmv=%b last=%b rnd=%0d, expected phase=%0d grn=%b gmv=%b last=%b rnd=%0d",
               name, act[7:6], act[5], act[4], act[3:2], act[1:0], ph, grn, gm, last, rnd);
    end
  endtask

  // Seven lock-high cycles take a fresh HOLD (cnt=0) all the way to RUN.
  task automatic goRun();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b0; loss = 2'b00; restart = 1'b0;

    // rst_n lock loss restart | phase grn gmv last rnd
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0};
    vecs[3]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00, 2'd0};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00, 2'd0};
    vecs[7]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd2, 1'b1, 1'b1, 2'b00, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd1};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd1};
    vecs[13] = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd1};
    vecs[14] = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 1'b0, 1'b1, 2'b10, 2'd1};
    vecs[15] = '{1'b1, 1'b1, 2'b01, 1'b0, 2'd1, 1'b0, 1'b1, 2'b10, 2'd1};
    vecs[16] = '{1'b1, 1'b1, 2'b01, 1'b0, 2'd1, 1'b0, 1'b1, 2'b10, 2'd1};
    vecs[17] = '{1'b1, 1'b1, 2'b01, 1'b0, 2'd2, 1'b1, 1'b1, 2'b10, 2'd1};
    vecs[18] = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd2, 1'b1, 1'b1, 2'b10, 2'd1};
    vecs[19] = '{1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 2'b11, 2'd2};

    @(negedge clk);
    $display("[TB] table: reset, lock-gated HOLD, loss capture, loss ignored in ARM");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].lock, vecs[i].loss, vecs[i].restart);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].ph, vecs[i].grn, vecs[i].gmv,
                  vecs[i].last, vecs[i].rnd);
    end
    checkOutput("strict_tracks_table", 1'b1, 2'd0, 1'b0, 1'b0, 2'b11, 2'd2);

    $display("[TB] round counter saturation and restart");
    goRun();
    checkOutput("run3", 1'b0, 2'd2, 1'b1, 1'b1, 2'b11, 2'd2);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    checkOutput("loss3", 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 2'd3);
    goRun();
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    checkOutput("loss4_sat", 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd3);
    goRun();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1);
    checkOutput("restart_over_loss", 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd3);
    goRun();
    checkOutput("run_after_restart", 1'b0, 2'd2, 1'b1, 1'b1, 2'b10, 2'd3);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
    checkOutput("restart_run", 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd3);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("hold_after_restart", 1'b0, 2'd0, 1'b0, 1'b0, 2'b10, 2'd3);

    $display("[TB] lock strictness and reset priority");
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    checkOutput("reset_lax", 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0);
    checkOutput("reset_strict", 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0);
    goRun();
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    checkOutput("strict_loss", 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 2'd1);
    goRun();
    checkOutput("strict_run", 1'b1, 2'd2, 1'b1, 1'b1, 2'b01, 2'd1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("strict_lockdrop", 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 2'd1);
    checkOutput("lax_lockdrop", 1'b0, 2'd2, 1'b1, 1'b1, 2'b01, 2'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("strict_arm_drop", 1'b1, 2'd0, 1'b0, 1'b0, 2'b01, 2'd1);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
    checkOutput("reset_with_loss", 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
